// File: rtl/fp64_pkg.sv
// Shared float64 datapath definitions: field widths, class codes, exception
// flag bits and the unpack FSM encoding.
package fp64_pkg;
  localparam int FRAC_W   = 52;
  localparam int EXP_W    = 11;
  localparam int Z_EXP_W  = 12;
  localparam int EXP_BIAS = 1023;
  localparam int EXP_MAX  = 2047;

  typedef enum logic [2:0] {
    CLS_ZERO      = 3'd0,
    CLS_SUBNORMAL = 3'd1,
    CLS_NORMAL    = 3'd2,
    CLS_INF       = 3'd3,
    CLS_QNAN      = 3'd4,
    CLS_SNAN      = 3'd5
  } fp_class_e;

  localparam logic [31:0] FLAG_INEXACT   = 32'd1;
  localparam logic [31:0] FLAG_UNDERFLOW = 32'd4;
  localparam logic [31:0] FLAG_OVERFLOW  = 32'd8;
  localparam logic [31:0] FLAG_INVALID   = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } unpack_state_e;
endpackage

// File: rtl/fp64_classify.sv
// Combinational float64 classifier on the unsigned magnitude bits a[62:0].
module fp64_classify
  import fp64_pkg::*;
(
  input  logic [62:0] a_i,
  output logic [2:0]  class_o
);
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  assign e = a_i[FRAC_W +: EXP_W];
  assign f = a_i[FRAC_W-1:0];

  always_comb begin
    class_o = CLS_NORMAL;
    if (e == '0) begin
      class_o = (f == '0) ? CLS_ZERO : CLS_SUBNORMAL;
    end else if (e == '1) begin
      if (f == '0)          class_o = CLS_INF;
      else if (f[FRAC_W-1]) class_o = CLS_QNAN;
      else                  class_o = CLS_SNAN;
    end
  end
endmodule

// File: rtl/unpack_float64.sv
// float64 unpack with iterative subnormal normalisation (ap_start/ap_done).
// Optional macro UNPACK_SNAN_FLAG_EN raises the invalid flag on SNAN inputs.
module unpack_float64
  import fp64_pkg::*;
#(
  parameter int NORM_STEP = 1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  output logic        z_sign,
  output logic [11:0] z_exp,
  output logic [63:0] z_sig,
  output logic [2:0]  z_class,
  input  logic [31:0] float_exception_flag_i,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld
);
  unpack_state_e state_q, state_d;
  logic          sign_q, sign_d;
  logic [11:0]   exp_q, exp_d;
  logic [63:0]   sig_q, sig_d;
  logic [2:0]    class_q, class_d;
  logic [2:0]    in_class;
  logic [3:0]    amt;

  fp64_classify u_classify (
    .a_i     (a[62:0]),
    .class_o (in_class)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    class_d = class_q;
    amt     = 4'd1;
    case (state_q)
      ST_IDLE: if (ap_start) begin
        sign_d  = a[63];
        class_d = in_class;
        case (in_class)
          CLS_NORMAL: begin
            exp_d = {1'b0, a[62:52]};
            sig_d = {11'd0, 1'b1, a[51:0]};
          end
          // Exponent starts at 1 and drops by one per bit of left shift.
          CLS_SUBNORMAL: begin
            exp_d = 12'd1;
            sig_d = {12'd0, a[51:0]};
          end
          CLS_ZERO: begin
            exp_d = '0;
            sig_d = '0;
          end
          default: begin
            exp_d = 12'(EXP_MAX);
            sig_d = {12'd0, a[51:0]};
          end
        endcase
        state_d = (in_class == CLS_SUBNORMAL) ? ST_NORM : ST_DONE;
      end
      ST_NORM: begin
        if (sig_q[52 -: NORM_STEP] == '0) amt = 4'(NORM_STEP);
        sig_d = sig_q << amt;
        exp_d = exp_q - {8'd0, amt};
        if (sig_d[52]) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      class_q <= class_d;
    end
  end

  assign ap_ready = (state_q == ST_DONE);
  assign ap_idle  = (state_q == ST_IDLE) && !ap_start;
  assign ap_done  = ap_ready || ap_idle;
  assign z_sign   = sign_q;
  assign z_exp    = exp_q;
  assign z_sig    = sig_q;
  assign z_class  = class_q;

`ifdef UNPACK_SNAN_FLAG_EN
  logic snan_done;
  assign snan_done = ap_ready && (class_q == CLS_SNAN);
  assign float_exception_flag_o = float_exception_flag_i | (snan_done ? FLAG_INVALID : 32'd0);
  assign float_exception_flag_o_ap_vld = snan_done;
`else
  assign float_exception_flag_o = float_exception_flag_i;
  assign float_exception_flag_o_ap_vld = 1'b0;
`endif
endmodule

// File: tb/tb_unpack_float64.sv
// Bench for unpack_float64: NORM_STEP=1 and NORM_STEP=4 instances side by side,
// directed table plus random operands checked against a field-level model.
module tb_unpack_float64;
`ifdef UNPACK_SNAN_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] a;
    logic        sign;
    logic [11:0] exp;
    logic [63:0] sig;
    logic [2:0]  cls;
    int          lat1;
    int          lat4;
  } vec_t;

  typedef struct {
    logic        done, ready, idle, sign, vld;
    logic [11:0] exp;
    logic [63:0] sig;
    logic [2:0]  cls;
    logic [31:0] fo;
  } res_t;

  logic        ap_clk = 1'b0, ap_rst = 1'b1, ap_start = 1'b0;
  logic [63:0] a = '0;
  logic [31:0] flag_i = '0;

  logic        done1, idle1, ready1, sign1, vld1, done4, idle4, ready4, sign4, vld4;
  logic [11:0] exp1, exp4;
  logic [63:0] sig1, sig4;
  logic [2:0]  cls1, cls4;
  logic [31:0] fo1, fo4;

  int n_tests = 0, n_fail = 0;

  always #5 ap_clk = ~ap_clk;

  unpack_float64 #(.NORM_STEP(1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(done1),
    .ap_idle(idle1), .ap_ready(ready1), .a(a), .z_sign(sign1), .z_exp(exp1),
    .z_sig(sig1), .z_class(cls1), .float_exception_flag_i(flag_i),
    .float_exception_flag_o(fo1), .float_exception_flag_o_ap_vld(vld1));

  unpack_float64 #(.NORM_STEP(4)) dut4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(done4),
    .ap_idle(idle4), .ap_ready(ready4), .a(a), .z_sign(sign4), .z_exp(exp4),
    .z_sig(sig4), .z_class(cls4), .float_exception_flag_i(flag_i),
    .float_exception_flag_o(fo4), .float_exception_flag_o_ap_vld(vld4));

  function automatic res_t snap(input bit four);
    res_t r;
    if (four) begin
      r.done = done4; r.ready = ready4; r.idle = idle4; r.sign = sign4; r.vld = vld4;
      r.exp = exp4; r.sig = sig4; r.cls = cls4; r.fo = fo4;
    end else begin
      r.done = done1; r.ready = ready1; r.idle = idle1; r.sign = sign1; r.vld = vld1;
      r.exp = exp1; r.sig = sig1; r.cls = cls1; r.fo = fo1;
    end
    return r;
  endfunction

  // Reference: decode fields, find leading one of f, derive shift and latency.
  function automatic vec_t model(input logic [63:0] av);
    vec_t v;
    int e, s, p;
    logic [51:0] f;
    e = int'(av[62:52]);
    f = av[51:0];
    v.a = av; v.sign = av[63]; v.lat1 = 1; v.lat4 = 1;
    if (e == 0 && f == 0) begin
      v.cls = 3'd0; v.exp = 12'd0; v.sig = 64'd0;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      s = 52 - p;
      v.cls = 3'd1;
      v.exp = 12'(1 - s);
      v.sig = {12'd0, f} << s;
      v.lat1 = 1 + s;
      v.lat4 = 1 + s / 4 + s % 4;
    end else if (e == 2047) begin
      v.cls = (f == 0) ? 3'd3 : (f[51] ? 3'd4 : 3'd5);
      v.exp = 12'd2047;
      v.sig = {12'd0, f};
    end else begin
      v.cls = 3'd2; v.exp = 12'(e); v.sig = {11'd0, 1'b1, f};
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_done(input string tag, input res_t r, input int k, input int lat,
                            input vec_t v, input logic [31:0] fi);
    logic snan;
    snan = FLAG_EN && (v.cls == 3'd5);
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " ap_done"}, 64'(r.done), 64'd1);
    chk({tag, " sign"}, 64'(r.sign), 64'(v.sign));
    chk({tag, " exp"}, 64'(r.exp), 64'(v.exp));
    chk({tag, " sig"}, r.sig, v.sig);
    chk({tag, " class"}, 64'(r.cls), 64'(v.cls));
    chk({tag, " flag_o"}, 64'(r.fo), 64'(snan ? (fi | 32'd16) : fi));
    chk({tag, " flag_vld"}, 64'(r.vld), 64'(snan));
  endtask

  // Start one operation; optionally pulse ap_start with a decoy operand at cycle pulse_at.
  task automatic run_op(input vec_t v, input logic [31:0] fi, input int pulse_at);
    bit d1, d4;
    res_t r;
    d1 = 0; d4 = 0;
    @(posedge ap_clk); #1;
    a = v.a; ap_start = 1'b1; flag_i = fi;
    @(negedge ap_clk);
    r = snap(0);
    chk("start-cycle ap_done", 64'(r.done), 64'd0);
    chk("start-cycle flag pass", {31'd0, r.vld, r.fo}, {32'd0, fi});
    @(posedge ap_clk); #1;
    for (int k = 1; k <= 120; k++) begin
      if (k == pulse_at) begin
        ap_start = 1'b1; a = 64'h3FF0000000000000;
      end else begin
        ap_start = 1'b0;
      end
      @(negedge ap_clk);
      r = snap(0);
      if (!d1 && r.ready) begin d1 = 1; check_done("ns1", r, k, v.lat1, v, fi); end
      r = snap(1);
      if (!d4 && r.ready) begin d4 = 1; check_done("ns4", r, k, v.lat4, v, fi); end
      if (d1 && d4) break;
      @(posedge ap_clk); #1;
    end
    ap_start = 1'b0;
    if (!(d1 && d4)) chk("done timeout", {62'd0, d1, d4}, 64'd3);
  endtask

  vec_t tbl[10];
  vec_t v;
  res_t r;
  logic [63:0] ra;
  bit seen;

  initial begin
    tbl[0] = '{64'h3FF0000000000000, 0, 12'h3FF, 64'h0010000000000000, 3'd2, 1, 1};
    tbl[1] = '{64'h0000000000000001, 0, 12'hFCD, 64'h0010000000000000, 3'd1, 53, 14};
    tbl[2] = '{64'h0008000000000000, 0, 12'h000, 64'h0010000000000000, 3'd1, 2, 2};
    tbl[3] = '{64'hFFF0000000000000, 1, 12'h7FF, 64'h0000000000000000, 3'd3, 1, 1};
    tbl[4] = '{64'h8000000000000000, 1, 12'h000, 64'h0000000000000000, 3'd0, 1, 1};
    tbl[5] = '{64'h7FF0000000000001, 0, 12'h7FF, 64'h0000000000000001, 3'd5, 1, 1};
    tbl[6] = '{64'h7FF8000000000000, 0, 12'h7FF, 64'h0008000000000000, 3'd4, 1, 1};
    tbl[7] = '{64'h000FFFFFFFFFFFFF, 0, 12'h000, 64'h001FFFFFFFFFFFFE, 3'd1, 2, 2};
    tbl[8] = '{64'h7FEFFFFFFFFFFFFF, 0, 12'h7FE, 64'h001FFFFFFFFFFFFF, 3'd2, 1, 1};
    tbl[9] = '{64'h0000000000000007, 0, 12'hFCF, 64'h001C000000000000, 3'd1, 51, 15};

    #12;
    for (int d = 0; d < 2; d++) begin
      r = snap(d[0]);
      chk("reset outputs", {r.sign, r.exp, r.cls}, 64'd0);
      chk("reset sig", r.sig, 64'd0);
      chk("reset handshake", {61'd0, r.done, r.idle, r.ready}, 64'b110);
    end
    @(posedge ap_clk); #1 ap_rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i], 32'h1, 0);

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: ra[62:52] = 11'd0;
        1: begin ra[62:52] = 11'd0; ra[51:0] = ra[51:0] >> $urandom_range(0, 51); end
        2: ra[62:52] = 11'h7FF;
        3: begin ra[62:52] = 11'h7FF; ra[51] = 1'b0; ra[50:0] = ra[50:0] >> $urandom_range(0, 50); end
        default: ;
      endcase
      run_op(model(ra), $urandom, 0);
    end

    // Start ignored mid-NORM: result must still be that of the subnormal operand.
    run_op(model(64'h0000000000000001), 32'h0, 5);

    // Reset mid-NORM abandons the operation.
    @(posedge ap_clk); #1;
    a = 64'h0000000000000001; ap_start = 1'b1;
    @(posedge ap_clk); #1 ap_start = 1'b0;
    repeat (5) @(posedge ap_clk);
    @(negedge ap_clk); ap_rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      r = snap(d[0]);
      chk("mid-reset outputs", {r.sign, r.exp, r.cls}, 64'd0);
      chk("mid-reset sig", r.sig, 64'd0);
      chk("mid-reset idle/ready", {62'd0, r.idle, r.ready}, 64'b10);
    end
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge ap_clk);
      if (ready1 || ready4) seen = 1;
    end
    chk("no completion after reset", 64'(seen), 64'd0);
    run_op(tbl[0], 32'h1, 0);
    run_op(tbl[5], 32'h1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
